// File: rtl/mdio_phy_emu.sv
// Clause-22 MDIO responder emulating a PHY register file; all protocol
// actions are taken in the clk cycle after a synchronized MDC rising edge.
module mdio_phy_emu #(
  parameter logic [4:0]  PHY_ADDR = 5'b0,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mdc,
  input  logic       mdio_i,
  output logic       mdio_o,
  output logic       mdio_oe,
  input  logic       link_up,
  input  logic [1:0] speed,
  input  logic       full_duplex,
  input  logic       link_change,
  output logic       intr_out,
  output logic       phy_reset_req
);

  typedef enum logic [2:0] {
    S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_RDATA, S_WDATA
  } state_t;

  logic [1:0]  mdc_s, mdio_s;
  logic        mdc_d, mdc_rise, bit_in;
  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [15:0] sh, sh_n, rd_data, wdata;
  logic [4:0]  regad, regad_n, addr_cur;
  logic        is_rd, is_rd_n, oe_n, o_n, rd_load, wr_commit;
  logic [14:0] ctrl;
  logic [15:0] adv;
  logic        ie, lat_link, chg_flag;

  assign mdc_rise = mdc_s[1] & ~mdc_d;
  assign bit_in   = mdio_s[1];
  assign addr_cur = {sh[3:0], bit_in};
  assign wdata    = {sh[14:0], bit_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_s  <= '0;
      mdio_s <= '0;
      mdc_d  <= 1'b0;
    end else begin
      mdc_s  <= {mdc_s[0], mdc};
      mdio_s <= {mdio_s[0], mdio_i};
      mdc_d  <= mdc_s[1];
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr_cur)
      5'd0:  rd_data = {1'b0, ctrl};
      5'd1:  rd_data = 16'h7949 | {10'b0, link_up, 2'b0, lat_link, 2'b0};
      5'd2:  rd_data = PHY_ID1;
      5'd3:  rd_data = PHY_ID2;
      5'd4:  rd_data = adv;
      5'd17: rd_data = {speed, full_duplex, 1'b0, 1'b1, link_up, 10'b0};
      5'd18: rd_data = {5'b0, ie, 10'b0};
      5'd19: rd_data = {5'b0, chg_flag, 10'b0};
      default: rd_data = '0;
    endcase
  end

  // cnt doubles as preamble counter and per-field bit counter
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sh_n      = sh;
    regad_n   = regad;
    is_rd_n   = is_rd;
    oe_n      = mdio_oe;
    o_n       = mdio_o;
    rd_load   = 1'b0;
    wr_commit = 1'b0;
    if (mdc_rise) begin
      case (state)
        S_PRE: begin
          if (bit_in) cnt_n = (cnt == 6'd32) ? cnt : cnt + 6'd1;
          else begin
            cnt_n = '0;
            if (cnt == 6'd32) state_n = S_ST;
          end
        end
        S_ST: begin
          cnt_n   = '0;
          state_n = bit_in ? S_OP : S_PRE;
        end
        S_OP: begin
          sh_n = wdata;
          if (cnt == 6'd0) cnt_n = 6'd1;
          else begin
            cnt_n = '0;
            if ({sh[0], bit_in} == 2'b10)      begin is_rd_n = 1'b1; state_n = S_PHYAD; end
            else if ({sh[0], bit_in} == 2'b01) begin is_rd_n = 1'b0; state_n = S_PHYAD; end
            else state_n = S_PRE;
          end
        end
        S_PHYAD: begin
          sh_n = wdata;
          if (cnt == 6'd4) begin
            cnt_n   = '0;
            state_n = (addr_cur == PHY_ADDR) ? S_REGAD : S_PRE;
          end else cnt_n = cnt + 6'd1;
        end
        S_REGAD: begin
          sh_n = wdata;
          if (cnt == 6'd4) begin
            cnt_n   = '0;
            regad_n = addr_cur;
            state_n = S_TA;
            if (is_rd) begin
              sh_n    = rd_data;
              rd_load = 1'b1;
            end
          end else cnt_n = cnt + 6'd1;
        end
        S_TA: begin
          if (is_rd) begin
            oe_n    = 1'b1;
            o_n     = 1'b0;
            cnt_n   = '0;
            state_n = S_RDATA;
          end else if (cnt == 6'd1) begin
            cnt_n   = '0;
            state_n = S_WDATA;
          end else cnt_n = 6'd1;
        end
        S_RDATA: begin
          if (cnt == 6'd16) begin
            oe_n    = 1'b0;
            o_n     = 1'b1;
            cnt_n   = '0;
            state_n = S_PRE;
          end else begin
            o_n   = sh[15];
            sh_n  = {sh[14:0], 1'b0};
            cnt_n = cnt + 6'd1;
          end
        end
        S_WDATA: begin
          sh_n = wdata;
          if (cnt == 6'd15) begin
            wr_commit = 1'b1;
            cnt_n     = '0;
            state_n   = S_PRE;
          end else cnt_n = cnt + 6'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_PRE;
      cnt     <= '0;
      sh      <= '0;
      regad   <= '0;
      is_rd   <= 1'b0;
      mdio_oe <= 1'b0;
      mdio_o  <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      regad   <= regad_n;
      is_rd   <= is_rd_n;
      mdio_oe <= oe_n;
      mdio_o  <= o_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl          <= 15'h1140;
      adv           <= 16'h01E1;
      ie            <= 1'b0;
      lat_link      <= 1'b0;
      chg_flag      <= 1'b0;
      intr_out      <= 1'b0;
      phy_reset_req <= 1'b0;
    end else begin
      phy_reset_req <= 1'b0;
      intr_out      <= chg_flag & ie;
      if (!link_up) lat_link <= 1'b0;
      else if (rd_load && addr_cur == 5'd1) lat_link <= 1'b1;
      // a coincident link_change wins over the clear-on-read
      if (link_change) chg_flag <= 1'b1;
      else if (rd_load && addr_cur == 5'd19) chg_flag <= 1'b0;
      if (wr_commit) begin
        case (regad)
          5'd0: begin
            if (wdata[15]) begin
              ctrl          <= 15'h1140;
              adv           <= 16'h01E1;
              ie            <= 1'b0;
              phy_reset_req <= 1'b1;
            end else ctrl <= wdata[14:0];
          end
          5'd4:  adv <= wdata;
          5'd18: ie  <= wdata[10];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_emu.sv
// Scoreboarded bench for mdio_phy_emu: a host task drives MDIO frames, a
// behavioural register model predicts reads, a monitor collects driven bits.
module tb_mdio_phy_emu;
  localparam logic [4:0] PA = 5'd5;

  logic clk, rst, mdc, mdio_i, mdio_o, mdio_oe;
  logic link_up, full_duplex, link_change, intr_out, phy_reset_req;
  logic [1:0] speed;

  mdio_phy_emu #(.PHY_ADDR(PA), .PHY_ID1(16'h0141), .PHY_ID2(16'h0CC2)) dut (
    .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .link_up(link_up), .speed(speed),
    .full_duplex(full_duplex), .link_change(link_change),
    .intr_out(intr_out), .phy_reset_req(phy_reset_req));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int oe_cycles = 0, preq_cycles = 0, exp_preq = 0;
  logic [15:0] sb[$];
  logic was_oe;

  // behavioural register model
  logic [15:0] m_ctrl, m_adv;
  logic m_ie, m_lat, m_chg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_ctrl = 16'h1140; m_adv = 16'h01E1; m_ie = 1'b0; m_lat = 1'b0; m_chg = 1'b0;
  endfunction

  function automatic logic [15:0] m_read(input logic [4:0] a);
    logic [15:0] v;
    case (a)
      5'd0:  v = m_ctrl;
      5'd1:  begin
        v = 16'h7949;
        if (link_up) v = v + 16'h0020;
        if (m_lat)   v = v + 16'h0004;
        m_lat = link_up;
      end
      5'd2:  v = 16'h0141;
      5'd3:  v = 16'h0CC2;
      5'd4:  v = m_adv;
      5'd17: v = 16'h0800 + (16'(speed) * 16'h4000) + (full_duplex ? 16'h2000 : 16'h0)
               + (link_up ? 16'h0400 : 16'h0);
      5'd18: v = m_ie ? 16'h0400 : 16'h0;
      5'd19: begin v = m_chg ? 16'h0400 : 16'h0; m_chg = 1'b0; end
      default: v = 16'h0;
    endcase
    return v;
  endfunction

  function automatic void m_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0) begin
      if (d >= 16'h8000) begin
        m_ctrl = 16'h1140; m_adv = 16'h01E1; m_ie = 1'b0; exp_preq++;
      end else m_ctrl = d;
    end else if (a == 5'd4) m_adv = d;
    else if (a == 5'd18) m_ie = (d & 16'h0400) != 0;
  endfunction

  always @(negedge clk) begin
    if (mdio_oe) oe_cycles++;
    if (phy_reset_req) preq_cycles++;
  end

  // host: data changes while mdc low, PHY samples on rise
  task automatic send_bit(input logic b, input bit lc);
    mdio_i = b;
    repeat (4) @(negedge clk);
    mdc = 1'b1;
    if (lc) begin
      repeat (2) @(negedge clk);
      link_change = 1'b1;
      @(negedge clk);
      link_change = 1'b0;
      @(negedge clk);
    end else repeat (4) @(negedge clk);
    mdc = 1'b0;
  endtask

  task automatic frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [15:0] wd, input int npre, input bit lc_k, input int abort_at);
    logic q[$];
    int klast;
    for (int i = 0; i < npre; i++) q.push_back(1'b1);
    q.push_back(1'b0); q.push_back(1'b1);
    q.push_back(op[1]); q.push_back(op[0]);
    for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
    klast = q.size() - 1;
    if (op == 2'b01) begin
      q.push_back(1'b1); q.push_back(1'b0);
      for (int i = 15; i >= 0; i--) q.push_back(wd[i]);
    end else for (int i = 0; i < 18; i++) q.push_back(1'b1);
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        was_oe = mdio_oe;
        rst = 1'b1;
        return;
      end
      send_bit(q[i], lc_k && (i == klast));
    end
    mdio_i = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_read(input logic [4:0] ra, input bit lc_k);
    logic [15:0] e;
    e = m_read(ra);
    if (lc_k) m_chg = 1'b1;
    sb.push_back(e);
    frame(2'b10, PA, ra, 16'h0, 32, lc_k, -1);
  endtask

  task automatic do_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
    if (phy == PA) m_write(ra, d);
    frame(2'b01, phy, ra, d, 32, 1'b0, -1);
  endtask

  task automatic pulse_lc();
    @(negedge clk); link_change = 1'b1;
    @(negedge clk); link_change = 1'b0;
    m_chg = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // monitor: gather bits the host would sample while the PHY drives
  initial begin
    logic [16:0] bits;
    int n;
    logic [15:0] e;
    forever begin
      @(posedge mdio_oe);
      n = 0; bits = '0;
      forever begin
        @(posedge mdc or negedge mdio_oe);
        if (!mdio_oe) break;
        bits = {bits[15:0], mdio_o};
        n++;
      end
      if (!rst) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_drive: got %0d driven bits expected none", n);
        end else begin
          e = sb.pop_front();
          chk("oe_mdc_cycles", n, 17);
          chk("rd_ta_data", {15'b0, bits}, {16'b0, e});
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int o, p, r;
    logic [4:0] a;
    logic [15:0] d;
    logic [4:0] alist[9];
    alist = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd17, 5'd18, 5'd19, 5'd9};
    rst = 1'b1; mdc = 1'b0; mdio_i = 1'b1; link_up = 1'b1;
    speed = 2'b10; full_duplex = 1'b1; link_change = 1'b0;
    m_reset();
    repeat (4) @(negedge clk);
    chk("rst_mdio_oe", mdio_oe, 0);
    chk("rst_mdio_o", mdio_o, 1);
    chk("rst_intr", intr_out, 0);
    chk("rst_preq", phy_reset_req, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // ID read, write/readback, wrong-address frames
    do_read(5'd2, 1'b0);
    do_read(5'd3, 1'b0);
    do_write(PA, 5'd4, 16'h0DE1);
    do_read(5'd4, 1'b0);
    o = oe_cycles;
    do_write(PA + 5'd1, 5'd4, 16'h1234);
    frame(2'b10, PA + 5'd1, 5'd4, 16'h0, 32, 1'b0, -1);
    chk("wrong_phy_oe", oe_cycles - o, 0);
    do_read(5'd4, 1'b0);

    // latch-low link status
    do_read(5'd1, 1'b0);
    link_up = 1'b0; m_lat = 1'b0;
    repeat (3) @(negedge clk);
    link_up = 1'b1;
    repeat (3) @(negedge clk);
    do_read(5'd1, 1'b0);
    do_read(5'd1, 1'b0);

    // interrupt path
    do_write(PA, 5'd18, 16'h0400);
    pulse_lc();
    chk("intr_set", intr_out, 1);
    do_read(5'd19, 1'b0);
    chk("intr_clr", intr_out, 0);
    pulse_lc();
    do_read(5'd19, 1'b1);
    chk("intr_coincide", intr_out, 1);
    do_read(5'd19, 1'b0);
    chk("intr_clr2", intr_out, 0);

    // software reset
    p = preq_cycles;
    do_write(PA, 5'd0, 16'h9140);
    chk("preq_pulse", preq_cycles - p, 1);
    do_read(5'd0, 1'b0);
    do_read(5'd4, 1'b0);
    do_read(5'd18, 1'b0);

    // malformed frames
    o = oe_cycles;
    frame(2'b10, PA, 5'd2, 16'h0, 31, 1'b0, -1);
    frame(2'b11, PA, 5'd2, 16'h0, 32, 1'b0, -1);
    chk("ignored_oe", oe_cycles - o, 0);
    do_read(5'd17, 1'b0);

    // randomized traffic
    for (int it = 0; it < 16; it++) begin
      r = $urandom_range(0, 9);
      a = alist[$urandom_range(0, 8)];
      d = 16'($urandom);
      if (r < 2) begin
        link_up = 1'($urandom_range(0, 1));
        speed = 2'($urandom_range(0, 2));
        full_duplex = 1'($urandom_range(0, 1));
        if (!link_up) m_lat = 1'b0;
        pulse_lc();
      end else if (r < 5) do_write(PA, a, d);
      else do_read(a, 1'b0);
      chk("intr_rand", intr_out, m_chg & m_ie);
    end
    link_up = 1'b1;
    repeat (3) @(negedge clk);

    // reset during read data phase
    frame(2'b10, PA, 5'd2, 16'h0, 32, 1'b0, 52);
    #1;
    chk("abort_was_driving", was_oe, 1);
    chk("abort_oe", mdio_oe, 0);
    chk("abort_o", mdio_o, 1);
    repeat (3) @(negedge clk);
    chk("abort_intr", intr_out, 0);
    rst = 1'b0; m_reset();
    mdio_i = 1'b1;
    repeat (4) @(negedge clk);
    do_read(5'd0, 1'b0);
    do_read(5'd4, 1'b0);

    repeat (10) @(negedge clk);
    chk("preq_total", preq_cycles, exp_preq);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
